// File: rtl/fetch_sequencer.sv
// Fetch sequencer: arbitrates one shared byte memory between the instruction
// byte stream (fetch unit) and single-byte data loads, and hands the fetch
// unit an update pulse once the executor finishes an instruction.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_request,
    input  logic        fetch_done,
    output logic [7:0]  data,
    output logic        data_ready,
    output logic        update,
    input  logic        exec_complete,
    input  logic        pc_load,
    input  logic [15:0] pc_value,
    output logic [15:0] pc,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    output logic        ld_valid,
    output logic [7:0]  ld_data,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StFRd,
        StFPres,
        StFGap,
        StWaitExec,
        StLRd,
        StLRsp
    } state_e;

    // Arbitration history: which requester was granted most recently.
    localparam logic GrantFetch = 1'b0;
    localparam logic GrantLoad  = 1'b1;

    state_e      r_state;
    state_e      w_state_d;
    logic [15:0] r_pc;
    logic [7:0]  r_data;
    logic [7:0]  r_ld_data;
    logic [15:0] r_mem_addr;
    logic        r_last_grant;
    logic        r_ret_wait;    // load originated in WAIT_EXEC
    logic        w_grant_fetch;
    logic        w_grant_load;
    logic        w_update;
    logic        w_fetch_ack;
    logic        w_load_ack;

    // Acks only count while the matching read is outstanding; stale acks drop.
    assign w_fetch_ack = (r_state == StFRd) && mem_ack;
    assign w_load_ack  = (r_state == StLRd) && mem_ack;

    // Next-state, grant decision and update pulse.
    always_comb begin
        w_state_d     = r_state;
        w_grant_fetch = 1'b0;
        w_grant_load  = 1'b0;
        w_update      = 1'b0;
        case (r_state)
            StIdle: begin
                if (ld_req && fetch_request) begin
                    if (r_last_grant == GrantFetch) begin
                        w_grant_load = 1'b1;
                    end else begin
                        w_grant_fetch = 1'b1;
                    end
                end else if (ld_req) begin
                    w_grant_load = 1'b1;
                end else if (fetch_request) begin
                    w_grant_fetch = 1'b1;
                end
                if (w_grant_load) begin
                    w_state_d = StLRd;
                end else if (w_grant_fetch) begin
                    w_state_d = StFRd;
                end
            end
            StFRd: begin
                if (mem_ack) begin
                    w_state_d = StFPres;
                end
            end
            StFPres: begin
                w_state_d = StFGap;
            end
            StFGap: begin
                w_state_d = fetch_done ? StWaitExec : StIdle;
            end
            StWaitExec: begin
                // A pending load is serviced before the instruction is retired.
                if (ld_req) begin
                    w_grant_load = 1'b1;
                    w_state_d    = StLRd;
                end else if (exec_complete) begin
                    w_update  = 1'b1;
                    w_state_d = StIdle;
                end
            end
            StLRd: begin
                if (mem_ack) begin
                    w_state_d = StLRsp;
                end
            end
            StLRsp: begin
                w_state_d = r_ret_wait ? StWaitExec : StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State, PC, captured bytes and latched read address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_data       <= 8'h00;
            r_ld_data    <= 8'h00;
            r_mem_addr   <= 16'h0000;
            r_last_grant <= GrantFetch;
            r_ret_wait   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            // Address is latched at grant so a pc_load mid-read cannot move it.
            if (w_grant_fetch) begin
                r_mem_addr   <= r_pc;
                r_last_grant <= GrantFetch;
            end
            if (w_grant_load) begin
                r_mem_addr   <= ld_addr;
                r_last_grant <= GrantLoad;
                r_ret_wait   <= (r_state == StWaitExec);
            end
            if (w_fetch_ack) begin
                r_data <= mem_rdata;
            end
            if (w_load_ack) begin
                r_ld_data <= mem_rdata;
            end
            // pc_load beats the post-fetch increment.
            if (pc_load) begin
                r_pc <= pc_value;
            end else if (w_fetch_ack) begin
                r_pc <= r_pc + 16'h0001;
            end
        end
    end

    assign data       = r_data;
    assign ld_data    = r_ld_data;
    assign pc         = r_pc;
    assign mem_addr   = r_mem_addr;
    assign mem_rd     = (r_state == StFRd) || (r_state == StLRd);
    assign data_ready = (r_state == StFPres);
    assign ld_valid   = (r_state == StLRsp);
    assign update     = w_update;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: behavioural byte memory with
// programmable ack latency, scoreboard queues for fetched and loaded bytes.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        fetch_request;
    logic        fetch_done;
    logic [7:0]  data;
    logic        data_ready;
    logic        update;
    logic        exec_complete;
    logic        pc_load;
    logic [15:0] pc_value;
    logic [15:0] pc;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    logic        auto_ack;
    logic [7:0]  auto_rdata;
    logic        inj_ack;
    int          mem_lat;
    int          lat_cnt;

    int          n_tests;
    int          n_fail;
    logic [15:0] exp_pc;
    logic [7:0]  fetch_q[$];
    logic [7:0]  load_q[$];

    fetch_sequencer #(
        .RESET_PC(16'h0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_request(fetch_request),
        .fetch_done   (fetch_done),
        .data         (data),
        .data_ready   (data_ready),
        .update       (update),
        .exec_complete(exec_complete),
        .pc_load      (pc_load),
        .pc_value     (pc_value),
        .pc           (pc),
        .ld_req       (ld_req),
        .ld_addr      (ld_addr),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents; address 0 holds 0x47.
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        if (a == 16'h0000) return 8'h47;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // Memory responder: ack mem_lat cycles after mem_rd rises, one cycle wide.
    always @(negedge clk) begin
        if (mem_rd && lat_cnt >= mem_lat) begin
            auto_ack   <= 1'b1;
            auto_rdata <= mem_model(mem_addr);
            lat_cnt    <= 0;
        end else begin
            auto_ack <= 1'b0;
            lat_cnt  <= mem_rd ? lat_cnt + 1 : 0;
        end
    end

    assign mem_ack   = auto_ack | inj_ack;
    assign mem_rdata = inj_ack ? 8'hEE : auto_rdata;

    function automatic logic out_sel(input int sel);
        case (sel)
            0:       return data_ready;
            1:       return ld_valid;
            2:       return mem_rd;
            default: return update;
        endcase
    endfunction

    // Wait (bounded) at negedges until the selected output is high.
    task automatic wait_out(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (out_sel(sel) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        exp_pc = 16'h0000;
    endtask

    task automatic test_reset();
        reset_dut();
        n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", pc); end
        n_tests++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data); end
        n_tests++; if (ld_data !== 8'h00) begin n_fail++; $display("FAIL reset_ld_data got=%h exp=00", ld_data); end
        n_tests++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready got=%b exp=0", data_ready); end
        n_tests++; if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update got=%b exp=0", update); end
        n_tests++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ld_valid got=%b exp=0", ld_valid); end
        n_tests++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        n_tests++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    endtask

    task automatic test_fetch();
        bit ok;
        logic [7:0] e;
        mem_lat = 0;
        fetch_request = 1'b1;
        fetch_q.push_back(mem_model(exp_pc));
        exp_pc = exp_pc + 16'h1;
        @(negedge clk);
        n_tests++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_rd got=%b exp=1", mem_rd); end
        n_tests++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL fetch_mem_addr got=%h exp=0000", mem_addr); end
        fetch_request = 1'b0;
        @(negedge clk);
        wait_out(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL fetch_dr_timeout got=0 exp=1"); end
        e = fetch_q.pop_front();
        n_tests++; if (data !== e) begin n_fail++; $display("FAIL fetch_data got=%h exp=%h", data, e); end
        n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL fetch_pc got=%h exp=%h", pc, exp_pc); end
        @(negedge clk);
        n_tests++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_dr_width got=%b exp=0", data_ready); end
    endtask

    task automatic test_instr_end();
        bit ok;
        int rd_seen;
        logic [7:0] e;
        @(negedge clk);
        fetch_request = 1'b1;
        fetch_done    = 1'b1;
        fetch_q.push_back(mem_model(exp_pc));
        exp_pc = exp_pc + 16'h1;
        @(negedge clk);
        wait_out(2, ok);
        fetch_request = 1'b0;
        @(negedge clk);
        wait_out(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL instr_dr_timeout got=0 exp=1"); end
        e = fetch_q.pop_front();
        n_tests++; if (data !== e) begin n_fail++; $display("FAIL instr_data got=%h exp=%h", data, e); end
        @(negedge clk);  // F_GAP, fetch_done high
        @(negedge clk);  // WAIT_EXEC
        fetch_done    = 1'b0;
        fetch_request = 1'b1;
        rd_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_rd === 1'b1) rd_seen++;
        end
        n_tests++; if (rd_seen != 0) begin n_fail++; $display("FAIL instr_no_fetch got=%0d exp=0", rd_seen); end
        fetch_request = 1'b0;
        exec_complete = 1'b1;
        #1;
        n_tests++; if (update !== 1'b1) begin n_fail++; $display("FAIL instr_update_hi got=%b exp=1", update); end
        @(negedge clk);
        n_tests++; if (update !== 1'b0) begin n_fail++; $display("FAIL instr_update_lo got=%b exp=0", update); end
        exec_complete = 1'b0;
        n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL instr_pc got=%h exp=%h", pc, exp_pc); end
    endtask

    task automatic test_contention();
        bit ok;
        logic [7:0] e;
        reset_dut();
        fetch_request = 1'b1;
        ld_req        = 1'b1;
        ld_addr       = 16'h8000;
        load_q.push_back(mem_model(16'h8000));
        load_q.push_back(mem_model(16'h8001));
        fetch_q.push_back(mem_model(16'h0000));
        fetch_q.push_back(mem_model(16'h0001));
        exp_pc = 16'h0002;
        @(negedge clk);
        n_tests++; if (mem_addr !== 16'h8000) begin n_fail++; $display("FAIL cont_first_load addr got=%h exp=8000", mem_addr); end
        @(negedge clk);
        wait_out(1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL cont_ldv1_timeout got=0 exp=1"); end
        e = load_q.pop_front();
        n_tests++; if (ld_data !== e) begin n_fail++; $display("FAIL cont_ld_data1 got=%h exp=%h", ld_data, e); end
        n_tests++; if (pc !== 16'h0000 || data !== 8'h00) begin
            n_fail++; $display("FAIL cont_load_side_effect got=pc %h data %h exp=pc 0000 data 00", pc, data);
        end
        ld_addr = 16'h8001;  // new request keeps ld_req high: tie, fetch's turn
        @(negedge clk);
        wait_out(2, ok);
        n_tests++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL cont_fetch_second addr got=%h exp=0000", mem_addr); end
        @(negedge clk);
        wait_out(0, ok);
        e = fetch_q.pop_front();
        n_tests++; if (data !== e) begin n_fail++; $display("FAIL cont_data1 got=%h exp=%h", data, e); end
        @(negedge clk);
        wait_out(2, ok);
        n_tests++; if (mem_addr !== 16'h8001) begin n_fail++; $display("FAIL cont_load_third addr got=%h exp=8001", mem_addr); end
        @(negedge clk);
        wait_out(1, ok);
        e = load_q.pop_front();
        n_tests++; if (ld_data !== e) begin n_fail++; $display("FAIL cont_ld_data2 got=%h exp=%h", ld_data, e); end
        ld_req = 1'b0;
        @(negedge clk);
        wait_out(2, ok);
        n_tests++; if (mem_addr !== 16'h0001) begin n_fail++; $display("FAIL cont_fetch_fourth addr got=%h exp=0001", mem_addr); end
        fetch_request = 1'b0;
        @(negedge clk);
        wait_out(0, ok);
        e = fetch_q.pop_front();
        n_tests++; if (data !== e) begin n_fail++; $display("FAIL cont_data2 got=%h exp=%h", data, e); end
        n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL cont_pc got=%h exp=%h", pc, exp_pc); end
        @(negedge clk);
    endtask

    task automatic test_load_wait_exec();
        bit ok;
        logic [7:0] e;
        mem_lat = 1;
        @(negedge clk);
        fetch_request = 1'b1;
        fetch_done    = 1'b1;
        fetch_q.push_back(mem_model(exp_pc));
        exp_pc = exp_pc + 16'h1;
        @(negedge clk);
        wait_out(2, ok);
        fetch_request = 1'b0;
        @(negedge clk);
        wait_out(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL lwe_dr_timeout got=0 exp=1"); end
        e = fetch_q.pop_front();
        n_tests++; if (data !== e) begin n_fail++; $display("FAIL lwe_data got=%h exp=%h", data, e); end
        @(negedge clk);  // F_GAP
        @(negedge clk);  // WAIT_EXEC
        fetch_done    = 1'b0;
        ld_req        = 1'b1;
        ld_addr       = 16'h4321;
        exec_complete = 1'b1;
        load_q.push_back(mem_model(16'h4321));
        #1;
        n_tests++; if (update !== 1'b0) begin n_fail++; $display("FAIL lwe_load_priority update got=%b exp=0", update); end
        @(negedge clk);
        n_tests++; if (mem_rd !== 1'b1 || mem_addr !== 16'h4321) begin
            n_fail++; $display("FAIL lwe_load_rd got=rd %b addr %h exp=rd 1 addr 4321", mem_rd, mem_addr);
        end
        wait_out(1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL lwe_ldv_timeout got=0 exp=1"); end
        e = load_q.pop_front();
        n_tests++; if (ld_data !== e) begin n_fail++; $display("FAIL lwe_ld_data got=%h exp=%h", ld_data, e); end
        ld_req = 1'b0;
        @(negedge clk);
        n_tests++; if (update !== 1'b1) begin n_fail++; $display("FAIL lwe_update_after_load got=%b exp=1", update); end
        @(negedge clk);
        n_tests++; if (update !== 1'b0) begin n_fail++; $display("FAIL lwe_update_width got=%b exp=0", update); end
        exec_complete = 1'b0;
        n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL lwe_pc got=%h exp=%h", pc, exp_pc); end
    endtask

    task automatic test_wrap_pcload();
        bit ok;
        bit acked;
        logic [7:0] e;
        mem_lat  = 0;
        @(negedge clk);
        pc_load  = 1'b1;
        pc_value = 16'hFFFF;
        @(negedge clk);
        pc_load  = 1'b0;
        n_tests++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pc_load got=%h exp=ffff", pc); end
        fetch_request = 1'b1;
        fetch_q.push_back(mem_model(16'hFFFF));
        @(negedge clk);
        wait_out(2, ok);
        n_tests++; if (mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_mem_addr got=%h exp=ffff", mem_addr); end
        fetch_request = 1'b0;
        @(negedge clk);
        wait_out(0, ok);
        e = fetch_q.pop_front();
        n_tests++; if (data !== e) begin n_fail++; $display("FAIL wrap_data got=%h exp=%h", data, e); end
        n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc got=%h exp=0000", pc); end
        @(negedge clk);
        @(negedge clk);
        mem_lat = 2;
        fetch_request = 1'b1;
        fetch_q.push_back(mem_model(16'h0000));
        @(negedge clk);
        wait_out(2, ok);
        fetch_request = 1'b0;
        acked = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            if (mem_ack === 1'b1) begin
                acked = 1'b1;
                break;
            end
        end
        pc_load  = 1'b1;
        pc_value = 16'h1234;
        @(negedge clk);
        pc_load  = 1'b0;
        n_tests++; if (!acked) begin n_fail++; $display("FAIL pcl_ack_timeout got=0 exp=1"); end
        n_tests++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL pcl_dr got=%b exp=1", data_ready); end
        e = fetch_q.pop_front();
        n_tests++; if (data !== e) begin n_fail++; $display("FAIL pcl_data got=%h exp=%h", data, e); end
        n_tests++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL pcl_pc got=%h exp=1234", pc); end
        @(negedge clk);
        @(negedge clk);
        exp_pc = 16'h1234;
    endtask

    task automatic test_reset_midread();
        bit ok;
        int bad;
        logic [7:0] e;
        mem_lat = 1000;
        fetch_request = 1'b1;
        @(negedge clk);
        wait_out(2, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_mid_rd_timeout got=0 exp=1"); end
        fetch_request = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_pc = 16'h0000;
        n_tests++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_rd got=%b exp=0", mem_rd); end
        n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_pc got=%h exp=0000", pc); end
        @(negedge clk);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (data_ready !== 1'b0 || mem_rd !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rst_stale_ack got=%0d exp=0", bad); end
        n_tests++; if (data !== 8'h00) begin n_fail++; $display("FAIL rst_stale_data got=%h exp=00", data); end
        mem_lat = 0;
        fetch_request = 1'b1;
        fetch_q.push_back(mem_model(exp_pc));
        exp_pc = exp_pc + 16'h1;
        @(negedge clk);
        wait_out(2, ok);
        fetch_request = 1'b0;
        @(negedge clk);
        wait_out(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_refetch_timeout got=0 exp=1"); end
        e = fetch_q.pop_front();
        n_tests++; if (data !== e) begin n_fail++; $display("FAIL rst_refetch_data got=%h exp=%h", data, e); end
        n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rst_refetch_pc got=%h exp=%h", pc, exp_pc); end
        @(negedge clk);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        exp_pc        = 16'h0000;
        reset         = 1'b1;
        fetch_request = 1'b0;
        fetch_done    = 1'b0;
        exec_complete = 1'b0;
        pc_load       = 1'b0;
        pc_value      = 16'h0000;
        ld_req        = 1'b0;
        ld_addr       = 16'h0000;
        inj_ack       = 1'b0;
        mem_lat       = 0;
        lat_cnt       = 0;
        auto_ack      = 1'b0;
        auto_rdata    = 8'h00;

        test_reset();
        test_fetch();
        test_instr_end();
        test_contention();
        test_load_wait_exec();
        test_wrap_pcload();
        test_reset_midread();

        n_tests++;
        if (fetch_q.size() != 0 || load_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", fetch_q.size(), load_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
